ssp_frame_rx: RTL and testbench
===============================

Name: ssp_frame_rx

Overview:
- ARM-side/loopback deserializer for the FPGA-to-ARM SSP correlation stream.
- Recovers 16-bit (I, Q) words from the ssp_frame/ssp_clk/ssp_din triple produced by the HF reader xcorr path.
- Runs on ck_1356meg and oversamples ssp_clk, which is fc/2.
- Used for FPGA self-test loopback and as the bench checker for the transmit side; reports words, framing errors and counts.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on each of ssp_frame/ssp_clk/ssp_din; identical depth on all three preserves relative alignment.
- WORD_BITS, 16, bits per word; must be even; upper half = I, lower half = Q.
- CNT_W, 8, width of the saturating word and error counters.

Ports:
- ck_1356meg  in  1  system clock, 13.56 MHz.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- ssp_frame  in  1  frame enable, active low; bits are clocked only while low.
- ssp_clk  in  1  serial clock; transmitter launches data on the rising edge.
- ssp_din  in  1  serial data, MSB first.
- corr_i  out  WORD_BITS/2  received I byte, signed.
- corr_q  out  WORD_BITS/2  received Q byte, signed.
- word_valid  out  1  one-cycle pulse; corr_i and corr_q are updated in the same cycle.
- frame_err  out  1  one-cycle pulse on a short frame.
- word_count  out  CNT_W  saturating count of good words.
- err_count  out  CNT_W  saturating count of frame errors.
- busy  out  1  high while in state SHIFT.

Behaviour:
- Reset: all outputs 0; shift register 0; bit counter 0; synchronizer flops preset to 1 (idle-high); state RESYNC.
- Edge detect: a sample event is the synchronized ssp_clk going from 1 to 0. ssp_din is sampled at that event, half an ssp_clk period after launch.
- States:
  - RESYNC: wait for the synchronized frame to be 1, then go to IDLE. This prevents capturing a frame that was already mid-flight when reset was released.
  - IDLE: when the synchronized frame is 0, go to SHIFT with the bit counter at 0. Sample events are ignored while the frame is high.
  - SHIFT: each sample event shifts ssp_din into the LSB of the shift register (the register shifts left) and increments the bit counter.
- Word complete: when the bit counter reaches WORD_BITS (16 events):
  - corr_i <= shreg[15:8]; corr_q <= shreg[7:0].
  - word_valid pulses on the cycle after the 16th event. Pin-to-pulse latency is SYNC_STAGES+2 ck_1356meg cycles after the ssp_clk falling edge at the pin.
  - word_count increments, saturating at 2^CNT_W-1.
  - The bit counter wraps to 0 and the state stays in SHIFT, so back-to-back words inside one frame are accepted.
- Frame end: synchronized ssp_frame rises while in SHIFT.
  - Bit counter = 0: return to IDLE silently.
  - Bit counter = 1..WORD_BITS-1: frame_err pulses, err_count increments (saturating), the partial word is discarded, and corr_i/corr_q hold their previous values.
- Simultaneous events: a sample event and a frame rise in the same cycle are resolved event first, then frame end. The 16th bit therefore completes a good word and no error is raised.
- Outputs corr_i and corr_q hold their values between words.
- Counters are cleared only by reset.
- Reset mid-frame: everything clears and the block re-enters RESYNC.

Decomposition:
- Shared package hf_ssp_pkg holds:
  - state encoding (RESYNC, IDLE, SHIFT);
  - constant SSP_WORD_BITS = 16;
  - constant SSP_FRAME_ACTIVE = 1'b0.
- Sub-module ssp_sync_edge: SYNC_STAGES synchronizer for the three inputs plus the ssp_clk falling-edge strobe. It is reused by any future ARM-to-FPGA SSP receiver.

Test Plan:
- Single frame: frame low, 16 bits 0x55AA at fc/2, frame high -> one word_valid with corr_i=0x55 and corr_q=0xAA; word_count=1; frame_err never asserted.
- Back-to-back: frame held low for 32 bits 0x7F80_8001 -> two word_valid pulses: (0x7F,0x80) then (0x80,0x01); word_count=2.
- Short frame: frame low, 9 bits, frame high -> frame_err pulses once; err_count=1; corr_i/corr_q unchanged; no word_valid.
- Boundary: frame rise in the same synchronized cycle as the 16th falling edge -> word_valid with correct data; err_count stays 0.
- Reset mid-frame: assert rst_n after 5 bits while the frame stays low and 11 more bits arrive -> no word_valid and no frame_err. The next full frame 0x1234 gives corr_i=0x12, corr_q=0x34.
- Saturation: 300 short frames -> err_count=0xFF and holds; a subsequent good frame still produces word_valid.

Source files
------------

// File: rtl/hf_ssp_pkg.sv
// Shared definitions for the HF reader SSP correlation stream (FPGA <-> ARM).
package hf_ssp_pkg;

  localparam int unsigned SSP_WORD_BITS    = 16;
  localparam logic        SSP_FRAME_ACTIVE = 1'b0;

  typedef logic [1:0] ssp_state_t;

  localparam ssp_state_t ST_RESYNC = 2'd0;
  localparam ssp_state_t ST_IDLE   = 2'd1;
  localparam ssp_state_t ST_SHIFT  = 2'd2;

endpackage

// File: rtl/ssp_sync_edge.sv
// Synchronizes ssp_frame/ssp_clk/ssp_din into the system clock domain and
// produces a registered ssp_clk falling-edge strobe aligned with frame and data.
module ssp_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ssp_frame,
  input  logic ssp_clk,
  input  logic ssp_din,
  output logic frame_s,
  output logic din_s,
  output logic fall,
  output logic sync_ok
);

  logic [SYNC_STAGES-1:0] frame_sr;
  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] din_sr;
  logic                   clk_prev;
  logic [SYNC_STAGES:0]   ok_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sr <= '1;
      clk_sr   <= '1;
      din_sr   <= '1;
      clk_prev <= 1'b1;
      frame_s  <= 1'b1;
      din_s    <= 1'b1;
      fall     <= 1'b0;
      ok_sr    <= '0;
    end else begin
      frame_sr[0] <= ssp_frame;
      clk_sr[0]   <= ssp_clk;
      din_sr[0]   <= ssp_din;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        frame_sr[i] <= frame_sr[i-1];
        clk_sr[i]   <= clk_sr[i-1];
        din_sr[i]   <= din_sr[i-1];
      end
      clk_prev <= clk_sr[SYNC_STAGES-1];
      // Strobe, frame and data share one output register stage so they stay aligned.
      fall     <= clk_prev & ~clk_sr[SYNC_STAGES-1];
      frame_s  <= frame_sr[SYNC_STAGES-1];
      din_s    <= din_sr[SYNC_STAGES-1];
      ok_sr    <= {ok_sr[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // High once the preset idle values have been flushed by real pin samples.
  assign sync_ok = ok_sr[SYNC_STAGES];

endmodule

// File: rtl/ssp_frame_rx.sv
// SSP frame receiver: recovers (I, Q) correlation words from ssp_frame/ssp_clk/ssp_din
// and reports good words, short-frame errors and saturating counts.
module ssp_frame_rx
  import hf_ssp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WORD_BITS   = SSP_WORD_BITS,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   ck_1356meg,
  input  logic                   rst_n,
  input  logic                   ssp_frame,
  input  logic                   ssp_clk,
  input  logic                   ssp_din,
  output logic [WORD_BITS/2-1:0] corr_i,
  output logic [WORD_BITS/2-1:0] corr_q,
  output logic                   word_valid,
  output logic                   frame_err,
  output logic [CNT_W-1:0]       word_count,
  output logic [CNT_W-1:0]       err_count,
  output logic                   busy
);

  localparam int unsigned HB = WORD_BITS / 2;
  localparam int unsigned BW = $clog2(WORD_BITS);

  logic                 frame_s;
  logic                 din_s;
  logic                 fall;
  logic                 sync_ok;
  ssp_state_t           state;
  logic [BW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] shreg;

  logic                 word_done;
  logic [BW-1:0]        cnt_nx;
  logic [WORD_BITS-1:0] shreg_nx;

  ssp_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (ck_1356meg),
    .rst_n    (rst_n),
    .ssp_frame(ssp_frame),
    .ssp_clk  (ssp_clk),
    .ssp_din  (ssp_din),
    .frame_s  (frame_s),
    .din_s    (din_s),
    .fall     (fall),
    .sync_ok  (sync_ok)
  );

  // Sample event is applied before frame end, so the 16th bit on a frame rise completes a word.
  always_comb begin
    word_done = 1'b0;
    cnt_nx    = bit_cnt;
    shreg_nx  = shreg;
    if (fall) begin
      shreg_nx = {shreg[WORD_BITS-2:0], din_s};
      if (bit_cnt == BW'(WORD_BITS - 1)) begin
        word_done = 1'b1;
        cnt_nx    = '0;
      end else begin
        cnt_nx = bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESYNC;
      bit_cnt    <= '0;
      shreg      <= '0;
      corr_i     <= '0;
      corr_q     <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      word_count <= '0;
      err_count  <= '0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_RESYNC: begin
          if (sync_ok && (frame_s != SSP_FRAME_ACTIVE)) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (frame_s == SSP_FRAME_ACTIVE) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          shreg   <= shreg_nx;
          bit_cnt <= cnt_nx;
          if (word_done) begin
            corr_i     <= shreg_nx[WORD_BITS-1:HB];
            corr_q     <= shreg_nx[HB-1:0];
            word_valid <= 1'b1;
            if (word_count != '1) begin
              word_count <= word_count + 1'b1;
            end
          end
          if (frame_s != SSP_FRAME_ACTIVE) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            if (cnt_nx != '0) begin
              frame_err <= 1'b1;
              if (err_count != '1) begin
                err_count <= err_count + 1'b1;
              end
            end
          end
        end
        default: state <= ST_RESYNC;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_ssp_frame_rx.sv
// Directed self-checking bench for ssp_frame_rx.
module tb_ssp_frame_rx;

  logic       ck_1356meg;
  logic       rst_n;
  logic       ssp_frame;
  logic       ssp_clk;
  logic       ssp_din;
  logic [7:0] corr_i;
  logic [7:0] corr_q;
  logic       word_valid;
  logic       frame_err;
  logic [7:0] word_count;
  logic [7:0] err_count;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int wv_n = 0;
  int fe_n = 0;
  logic [15:0] cap[$];

  int wv_base;
  int fe_base;
  int cap_base;

  ssp_frame_rx #(
    .SYNC_STAGES(2),
    .WORD_BITS  (16),
    .CNT_W      (8)
  ) dut (
    .ck_1356meg(ck_1356meg),
    .rst_n     (rst_n),
    .ssp_frame (ssp_frame),
    .ssp_clk   (ssp_clk),
    .ssp_din   (ssp_din),
    .corr_i    (corr_i),
    .corr_q    (corr_q),
    .word_valid(word_valid),
    .frame_err (frame_err),
    .word_count(word_count),
    .err_count (err_count),
    .busy      (busy)
  );

  initial ck_1356meg = 1'b0;
  always #37 ck_1356meg = ~ck_1356meg;

  always @(negedge ck_1356meg) begin
    if (rst_n && word_valid) begin
      wv_n = wv_n + 1;
      cap.push_back({corr_i, corr_q});
    end
    if (rst_n && frame_err) fe_n = fe_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge ck_1356meg);
    ssp_clk = 1'b1;
    ssp_din = b;
    @(negedge ck_1356meg);
    ssp_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, input bit rise_last);
    @(negedge ck_1356meg);
    ssp_frame = 1'b0;
    repeat (5) @(negedge ck_1356meg);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(data[nbits-1-i]);
    end
    if (rise_last) ssp_frame = 1'b1;
    else begin
      @(negedge ck_1356meg);
      ssp_frame = 1'b1;
    end
    repeat (8) @(negedge ck_1356meg);
  endtask

  task automatic snap();
    wv_base  = wv_n;
    fe_base  = fe_n;
    cap_base = cap.size();
  endtask

  initial begin
    rst_n     = 1'b0;
    ssp_frame = 1'b1;
    ssp_clk   = 1'b1;
    ssp_din   = 1'b0;
    repeat (3) @(negedge ck_1356meg);
    rst_n = 1'b1;
    @(negedge ck_1356meg);

    check("rst_corr_i", 32'(corr_i), 32'h0);
    check("rst_corr_q", 32'(corr_q), 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_word_count", 32'(word_count), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (6) @(negedge ck_1356meg);

    // Single frame 0x55AA with pin-to-pulse latency check
    snap();
    ssp_frame = 1'b0;
    repeat (5) @(negedge ck_1356meg);
    check("busy_in_frame", 32'(busy), 32'h1);
    for (int i = 0; i < 16; i++) drive_bit(logic'((16'h55AA >> (15 - i)) & 16'h1));
    repeat (3) @(negedge ck_1356meg);
    check("lat_early", 32'(word_valid), 32'h0);
    @(negedge ck_1356meg);
    check("lat_pulse", 32'(word_valid), 32'h1);
    @(negedge ck_1356meg);
    check("pulse_one_cycle", 32'(word_valid), 32'h0);
    ssp_frame = 1'b1;
    repeat (8) @(negedge ck_1356meg);
    check("single_wv_n", 32'(wv_n - wv_base), 32'd1);
    check("single_i", 32'(corr_i), 32'h55);
    check("single_q", 32'(corr_q), 32'hAA);
    check("single_wcnt", 32'(word_count), 32'd1);
    check("single_fe_n", 32'(fe_n - fe_base), 32'd0);
    check("single_busy_after", 32'(busy), 32'h0);

    // Back-to-back words in one frame
    snap();
    send_frame(32'h7F80_8001, 32, 1'b0);
    check("b2b_wv_n", 32'(wv_n - wv_base), 32'd2);
    if (cap.size() >= cap_base + 2) begin
      check("b2b_word0", 32'(cap[cap_base]), 32'h7F80);
      check("b2b_word1", 32'(cap[cap_base+1]), 32'h8001);
    end else begin
      check("b2b_captures", 32'(cap.size() - cap_base), 32'd2);
    end
    check("b2b_wcnt", 32'(word_count), 32'd3);
    check("b2b_fe_n", 32'(fe_n - fe_base), 32'd0);

    // Short frame: 9 bits
    snap();
    send_frame(32'h0000_01A5, 9, 1'b0);
    check("short_fe_n", 32'(fe_n - fe_base), 32'd1);
    check("short_ecnt", 32'(err_count), 32'd1);
    check("short_wv_n", 32'(wv_n - wv_base), 32'd0);
    check("short_i_hold", 32'(corr_i), 32'h80);
    check("short_q_hold", 32'(corr_q), 32'h01);
    check("short_wcnt", 32'(word_count), 32'd3);

    // Frame rise coincident with the 16th falling edge
    snap();
    send_frame(32'h0000_C33C, 16, 1'b1);
    check("bound_wv_n", 32'(wv_n - wv_base), 32'd1);
    check("bound_i", 32'(corr_i), 32'hC3);
    check("bound_q", 32'(corr_q), 32'h3C);
    check("bound_ecnt", 32'(err_count), 32'd1);
    check("bound_fe_n", 32'(fe_n - fe_base), 32'd0);
    check("bound_wcnt", 32'(word_count), 32'd4);

    // Reset mid-frame: 5 bits, reset, 11 more bits with frame still low
    @(negedge ck_1356meg);
    ssp_frame = 1'b0;
    repeat (5) @(negedge ck_1356meg);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    @(negedge ck_1356meg);
    rst_n = 1'b0;
    @(negedge ck_1356meg);
    rst_n = 1'b1;
    check("mrst_wcnt", 32'(word_count), 32'd0);
    check("mrst_ecnt", 32'(err_count), 32'd0);
    check("mrst_i", 32'(corr_i), 32'h0);
    snap();
    for (int i = 0; i < 11; i++) drive_bit(1'b1);
    @(negedge ck_1356meg);
    ssp_frame = 1'b1;
    repeat (8) @(negedge ck_1356meg);
    check("mrst_wv_n", 32'(wv_n - wv_base), 32'd0);
    check("mrst_fe_n", 32'(fe_n - fe_base), 32'd0);
    check("mrst_ecnt_after", 32'(err_count), 32'd0);
    send_frame(32'h0000_1234, 16, 1'b0);
    check("post_rst_i", 32'(corr_i), 32'h12);
    check("post_rst_q", 32'(corr_q), 32'h34);
    check("post_rst_wcnt", 32'(word_count), 32'd1);
    check("post_rst_wv_n", 32'(wv_n - wv_base), 32'd1);

    // Error counter saturation
    snap();
    for (int k = 0; k < 300; k++) send_frame(32'h1, 1, 1'b0);
    check("sat_fe_n", 32'(fe_n - fe_base), 32'd300);
    check("sat_ecnt", 32'(err_count), 32'hFF);
    send_frame(32'h0, 3, 1'b0);
    check("sat_fe_n_more", 32'(fe_n - fe_base), 32'd301);
    check("sat_ecnt_hold", 32'(err_count), 32'hFF);
    snap();
    send_frame(32'h0000_A55A, 16, 1'b0);
    check("sat_good_wv_n", 32'(wv_n - wv_base), 32'd1);
    check("sat_good_i", 32'(corr_i), 32'hA5);
    check("sat_good_q", 32'(corr_q), 32'h5A);
    check("sat_good_wcnt", 32'(word_count), 32'd2);
    check("sat_good_ecnt", 32'(err_count), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
